// File: rtl/button_event_decoder_pkg.sv
// Shared button timing defaults and FSM state encoding for the button event decoder
// and the top-level UI timing logic.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2,
    ST_UNUSED  = 2'd3
  } btn_state_t;

  localparam int unsigned LONG_CYCLES_DEF   = 25_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 6_250_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_hold_timer.sv
// Hold-duration counter: synchronous clear beats enable, optional saturation at all-ones,
// and a combinational terminal-count compare against a caller-supplied value.
module hold_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Clear,
  input  logic             i_Enable,
  input  logic             i_Saturate,
  input  logic [CNT_W-1:0] i_Tc_Val,
  output logic             o_Tc
);

  logic [CNT_W-1:0] r_Count;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Count <= '0;
    end else if (i_Clear) begin
      r_Count <= '0;
    end else if (i_Enable && !(i_Saturate && (r_Count == '1))) begin
      r_Count <= r_Count + CNT_W'(1);
    end
  end

  assign o_Tc = (r_Count == i_Tc_Val);

endmodule

// File: rtl/button_event_decoder.sv
// Debounced switch level to one-cycle press/release/short/long/repeat pulses.
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise o_Repeat is 0.
module button_event_decoder
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Short,
  output logic o_Long,
  output logic o_Repeat,
  output logic o_Held
);

  localparam int unsigned      CNT_W   = $clog2(max_u(LONG_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);

  btn_state_t r_State;
  btn_state_t w_Next;

  logic r_Prev;
  logic r_Press;
  logic r_Release;
  logic r_Short;
  logic r_Long;
  logic r_Held;

  logic w_Rise;
  logic w_Fall;
  logic w_Press;
  logic w_Release;
  logic w_Short;
  logic w_Long;
  logic w_Clear;
  logic w_Enable;
  logic w_Tc;
  logic [CNT_W-1:0] w_Tc_Val;

  assign w_Rise = i_Switch & ~r_Prev;
  assign w_Fall = ~i_Switch & r_Prev;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYCLES - 1);
  logic r_Repeat;
  logic w_Repeat;
  assign w_Tc_Val = (r_State == ST_LONG) ? REP_TC : LONG_TC;
  assign o_Repeat = r_Repeat;
`else
  assign w_Tc_Val = LONG_TC;
  assign o_Repeat = 1'b0;
`endif

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold_timer (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Clear    (w_Clear),
    .i_Enable   (w_Enable),
    .i_Saturate (1'b1),
    .i_Tc_Val   (w_Tc_Val),
    .o_Tc       (w_Tc)
  );

  // The timer is held clear throughout IDLE, so it is already zero on the cycle after a press.
  always_comb begin
    w_Next    = r_State;
    w_Press   = 1'b0;
    w_Release = 1'b0;
    w_Short   = 1'b0;
    w_Long    = 1'b0;
    w_Clear   = 1'b0;
    w_Enable  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    w_Repeat  = 1'b0;
`endif
    case (r_State)
      ST_IDLE: begin
        w_Clear = 1'b1;
        if (w_Rise) begin
          w_Next  = ST_PRESSED;
          w_Press = 1'b1;
        end
      end
      ST_PRESSED: begin
        w_Enable = 1'b1;
        if (w_Fall) begin
          w_Next    = ST_IDLE;
          w_Release = 1'b1;
          w_Short   = 1'b1;
        end else if (w_Tc) begin
          w_Next  = ST_LONG;
          w_Long  = 1'b1;
          w_Clear = 1'b1;
        end
      end
      ST_LONG: begin
        w_Enable = 1'b1;
        if (w_Fall) begin
          w_Next    = ST_IDLE;
          w_Release = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (w_Tc) begin
          w_Repeat = 1'b1;
          w_Clear  = 1'b1;
        end
`endif
      end
      default: begin
        w_Next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State   <= ST_IDLE;
      r_Prev    <= 1'b1;
      r_Press   <= 1'b0;
      r_Release <= 1'b0;
      r_Short   <= 1'b0;
      r_Long    <= 1'b0;
      r_Held    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_Repeat  <= 1'b0;
`endif
    end else begin
      r_State   <= w_Next;
      r_Prev    <= i_Switch;
      r_Press   <= w_Press;
      r_Release <= w_Release;
      r_Short   <= w_Short;
      r_Long    <= w_Long;
      r_Held    <= (w_Next == ST_PRESSED) || (w_Next == ST_LONG);
`ifdef BTN_AUTOREPEAT_EN
      r_Repeat  <= w_Repeat;
`endif
    end
  end

  assign o_Press   = r_Press;
  assign o_Release = r_Release;
  assign o_Short   = r_Short;
  assign o_Long    = r_Long;
  assign o_Held    = r_Held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event_decoder;

  localparam int LONG_C = 8;
  localparam int REP_C  = 4;

  localparam logic [4:0] EV_PRESS = 5'b00001;
  localparam logic [4:0] EV_REL   = 5'b00010;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b01000;
  localparam logic [4:0] EV_REP   = 5'b10000;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  logic i_Clk = 1'b0;
  logic i_Rst_L = 1'b0;
  logic i_Switch = 1'b0;
  logic o_Press, o_Release, o_Short, o_Long, o_Repeat, o_Held;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  logic [4:0] obs;
  logic [4:0] expv;
  logic       held_exp;

  always #5 i_Clk = ~i_Clk;

  button_event_decoder #(
    .LONG_CYCLES  (LONG_C),
    .REPEAT_CYCLES(REP_C)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Switch (i_Switch),
    .o_Press  (o_Press),
    .o_Release(o_Release),
    .o_Short  (o_Short),
    .o_Long   (o_Long),
    .o_Repeat (o_Repeat),
    .o_Held   (o_Held)
  );

  // Expected pulses for a rise driven at step d and held high for h steps.
  task automatic push_hold(input int d, input int h);
    sb.push_back('{d + 1, EV_PRESS});
    if (h > LONG_C) begin
      sb.push_back('{d + 1 + LONG_C, EV_LONG});
`ifdef BTN_AUTOREPEAT_EN
      for (int k = 1; REP_C * k < h - LONG_C; k++)
        sb.push_back('{d + 1 + LONG_C + REP_C * k, EV_REP});
`endif
      sb.push_back('{d + h + 1, EV_REL});
    end else begin
      sb.push_back('{d + h + 1, EV_REL | EV_SHORT});
    end
  endtask

  task automatic pop_expected();
    expv = '0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      if (sb[0].cyc == cyc) expv = sb[0].ev;
      void'(sb.pop_front());
    end
    obs = {o_Repeat, o_Long, o_Short, o_Release, o_Press};
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge i_Clk); cyc++; #1;
      pop_expected();
      if (k > 0) begin
        n_assert++;
        if (obs !== 5'b0 || o_Held !== 1'b0) begin
          n_fail++;
          $display("FAIL reset cyc=%0d got ev=%b held=%b exp ev=00000 held=0", cyc, obs, o_Held);
        end
      end
      i_Rst_L  = (k >= 2);
      i_Switch = 1'b0;
    end
  endtask

  task automatic test_short();
    int base, d;
    base = cyc + 1; d = base + 2;
    push_hold(d, 3);
    for (int k = 0; k < 2 + 3 + 5; k++) begin
      @(posedge i_Clk); cyc++; #1;
      pop_expected();
      held_exp = (cyc >= d + 1) && (cyc <= d + 3);
      n_assert++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL short_events cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      n_assert++;
      if (o_Held !== held_exp) begin
        n_fail++; $display("FAIL short_held cyc=%0d got=%b exp=%b", cyc, o_Held, held_exp);
      end
      i_Switch = (k >= 2) && (k < 5);
    end
  endtask

  task automatic test_long();
    int base, d;
    base = cyc + 1; d = base + 1;
    push_hold(d, 20);
    for (int k = 0; k < 1 + 20 + 5; k++) begin
      @(posedge i_Clk); cyc++; #1;
      pop_expected();
      held_exp = (cyc >= d + 1) && (cyc <= d + 20);
      n_assert++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL long_events cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      n_assert++;
      if (o_Held !== held_exp) begin
        n_fail++; $display("FAIL long_held cyc=%0d got=%b exp=%b", cyc, o_Held, held_exp);
      end
      i_Switch = (k >= 1) && (k < 21);
    end
  endtask

  task automatic test_threshold();
    int base, d;
    base = cyc + 1; d = base + 1;
    push_hold(d, LONG_C);
    for (int k = 0; k < 1 + LONG_C + 6; k++) begin
      @(posedge i_Clk); cyc++; #1;
      pop_expected();
      held_exp = (cyc >= d + 1) && (cyc <= d + LONG_C);
      n_assert++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL threshold_events cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      n_assert++;
      if (o_Held !== held_exp) begin
        n_fail++; $display("FAIL threshold_held cyc=%0d got=%b exp=%b", cyc, o_Held, held_exp);
      end
      i_Switch = (k >= 1) && (k < 1 + LONG_C);
    end
  endtask

  task automatic test_repeat();
    int base, d;
    base = cyc + 1; d = base + 1;
    push_hold(d, 30);
    for (int k = 0; k < 1 + 30 + 6; k++) begin
      @(posedge i_Clk); cyc++; #1;
      pop_expected();
      held_exp = (cyc >= d + 1) && (cyc <= d + 30);
      n_assert++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL repeat_events cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      n_assert++;
      if (o_Held !== held_exp) begin
        n_fail++; $display("FAIL repeat_held cyc=%0d got=%b exp=%b", cyc, o_Held, held_exp);
      end
      i_Switch = (k >= 1) && (k < 31);
    end
  endtask

  task automatic test_back_to_back();
    int base, d1, d2;
    base = cyc + 1; d1 = base + 1; d2 = base + 4;
    push_hold(d1, 2);
    push_hold(d2, 3);
    for (int k = 0; k < 12; k++) begin
      @(posedge i_Clk); cyc++; #1;
      pop_expected();
      held_exp = ((cyc >= d1 + 1) && (cyc <= d1 + 2)) || ((cyc >= d2 + 1) && (cyc <= d2 + 3));
      n_assert++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL b2b_events cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      n_assert++;
      if (o_Held !== held_exp) begin
        n_fail++; $display("FAIL b2b_held cyc=%0d got=%b exp=%b", cyc, o_Held, held_exp);
      end
      i_Switch = ((k >= 1) && (k < 3)) || ((k >= 4) && (k < 7));
    end
  endtask

  // Switch held high across reset release must stay silent until a fresh press.
  task automatic test_held_through_reset();
    int base, d;
    base = cyc + 1; d = base + 11;
    push_hold(d, 3);
    for (int k = 0; k < 11 + 3 + 5; k++) begin
      @(posedge i_Clk); cyc++; #1;
      pop_expected();
      held_exp = (cyc >= d + 1) && (cyc <= d + 3);
      n_assert++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL held_rst_events cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      n_assert++;
      if (o_Held !== held_exp) begin
        n_fail++; $display("FAIL held_rst_held cyc=%0d got=%b exp=%b", cyc, o_Held, held_exp);
      end
      i_Rst_L  = (k >= 3);
      i_Switch = (k < 8) || ((k >= 11) && (k < 14));
    end
  endtask

  task automatic test_reset_in_long();
    int base, d;
    base = cyc + 1; d = base + 1;
    sb.push_back('{d + 1, EV_PRESS});
    sb.push_back('{d + 1 + LONG_C, EV_LONG});
    for (int k = 0; k < 24; k++) begin
      @(posedge i_Clk); cyc++; #1;
      pop_expected();
      held_exp = (cyc >= d + 1) && (cyc <= d + 10);
      n_assert++;
      if (obs !== expv) begin
        n_fail++; $display("FAIL rst_long_events cyc=%0d got=%b exp=%b", cyc, obs, expv);
      end
      n_assert++;
      if (o_Held !== held_exp) begin
        n_fail++; $display("FAIL rst_long_held cyc=%0d got=%b exp=%b", cyc, o_Held, held_exp);
      end
      i_Rst_L  = !((k >= 11) && (k < 14));
      i_Switch = (k >= 1) && (k < 17);
    end
  endtask

  initial begin
    i_Rst_L  = 1'b0;
    i_Switch = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_threshold();
    test_back_to_back();
    test_repeat();
    test_held_through_reset();
    test_reset_in_long();
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained got=%0d pending exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
